calc_param_core: RTL and testbench
==================================

CALC_PARAM_CORE -- requirements
Module: calc_param_core

Interface
REQ-001 Parameter: DIGITS, default 8, legal range 2..9; number of decimal display digits and operand digits.
REQ-002 Derived constants: MAXV = 10^DIGITS-1; W = ceil(log2(MAXV+1)), which is 27 for DIGITS=8.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  one-cycle strobe; cmd sampled only when cmd_valid=1 and ready=1.
REQ-006 cmd  input  4  command code: 0-9 digit, 1010 ADD, 1011 SUB, 1100 MUL, 1101 CLEAR, 1110 EQUALS, 1111 CE (clear entry).
REQ-007 ready  output  1  1 when a command can be accepted.
REQ-008 displays  output  [DIGITS-1:0][6:0]  seven-segment patterns, active-low, bit order {g,f,e,d,c,b,a}; index 0 is the rightmost digit.
REQ-009 status  output  2  00 entry, 01 busy, 10 result valid, 11 error.
REQ-010 EA  output  3  current state encoding.
REQ-011 PE  output  3  next state encoding.

Function
REQ-012 States SHALL be S_ENTRY_A=0, S_ENTRY_B=1, S_MUL=2, S_CONV=3, S_RESULT=4, S_ERROR=5; values 6-7 SHALL be unreachable and SHALL decode to S_ERROR.
REQ-013 A digit in S_ENTRY_A/B SHALL shift into the BCD entry register and update the binary operand as op*10+d; once DIGITS digits have been entered, further digits are ignored.
REQ-014 During entry, displays SHALL show the BCD entry register with leading zeros blanked; a zero value shows a single "0" at index 0.
REQ-015 ADD/SUB/MUL in S_ENTRY_A SHALL latch the operator, store A, clear the entry, and move to S_ENTRY_B.
REQ-016 ADD/SUB/MUL in S_ENTRY_B SHALL replace the latched operator and keep the B entry unchanged.
REQ-017 EQUALS in S_ENTRY_B SHALL start the computation; EQUALS in S_ENTRY_A or S_RESULT is ignored.
REQ-018 ADD and SUB SHALL be computed at the EQUALS edge and SHALL enter S_CONV.
REQ-019 MUL SHALL enter S_MUL and perform shift-add over exactly W cycles into a 2W-bit product, then enter S_CONV.
REQ-020 Error conditions: ADD result > MAXV, SUB with B > A, or MUL product > MAXV; each SHALL go to S_ERROR instead of S_CONV.
REQ-021 S_CONV SHALL run the binary-to-BCD converter for exactly W cycles, then enter S_RESULT.
REQ-022 ready SHALL be 0 for exactly W+1 cycles after EQUALS for ADD/SUB, and for exactly 2W+1 cycles for MUL.
REQ-023 Commands strobed while ready=0 SHALL be dropped with no effect, including CLEAR.
REQ-024 In S_RESULT, displays SHALL show the result with leading zeros blanked.
REQ-025 A digit in S_RESULT SHALL start a new A with that digit and go to S_ENTRY_A.
REQ-026 An operator in S_RESULT SHALL take the result as A, latch the operator, and go to S_ENTRY_B (chaining).
REQ-027 In S_ERROR, displays SHALL show "E" at index 0 with all other digits blank; only CLEAR is accepted.
REQ-028 CLEAR (when ready=1) SHALL zero all operands and go to S_ENTRY_A.
REQ-029 CE SHALL zero only the current entry and keep the state.
REQ-030 status SHALL be a pure function of EA: ENTRY_x gives 00, MUL/CONV give 01, RESULT gives 10, ERROR gives 11.
REQ-031 PE SHALL be the combinational next-state value.

Reset
REQ-032 reset=0 SHALL immediately force EA=S_ENTRY_A, clear all operands, the entry register, and the converter state, and set ready=1 and status=00.
REQ-033 During reset, displays SHALL show "0" at index 0 with all other digits blank.
REQ-034 Reset asserted mid-S_MUL or mid-S_CONV SHALL abort the operation with no residual effect after release.

Structure
REQ-035 Package calc_pkg SHALL hold the state enum, the cmd code constants, and the BCD-to-seven-segment function.
REQ-036 Sub-module calc_bin2bcd SHALL be a sequential double-dabble converter with start/done handshake, parameterised by W and DIGITS, taking W cycles.
REQ-037 The multiplier SHALL be inline in calc_param_core and SHALL NOT be a separate module.

Verification (DIGITS=8)
REQ-038 Scenario 1, add: 1,2,ADD,3,EQUALS. Required: ready low 28 cycles, then displays "15", status=10.
REQ-039 Scenario 2, multiply and chain: 7,MUL,6,EQUALS. Required: ready low 55 cycles, displays "42". Then ADD,8,EQUALS. Required: "50".
REQ-040 Scenario 3, negative subtract: 5,SUB,9,EQUALS. Required: status=11 and "E" displayed. A digit strobe SHALL be ignored; CLEAR SHALL return to "0", status=00.
REQ-041 Scenario 4, overflow and digit limit: enter nine 9s; the ninth SHALL be ignored, display "99999999". Then ADD,1,EQUALS. Required: status=11.
REQ-042 Scenario 5, busy drop and reset abort: strobe CLEAR while in S_MUL; it SHALL be dropped. Assert reset=0 mid-S_MUL; required: EA=0 immediately and display "0" after release.
REQ-043 Scenario 6, DIGITS=4: 9999,ADD,1,EQUALS. Required: error. 99,MUL,99,EQUALS. Required: "9801".

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the parameterised calculator: state codes, command codes,
// operator codes and the BCD to seven-segment decoder.
package calc_pkg;

    localparam logic [2:0] S_ENTRY_A = 3'd0;
    localparam logic [2:0] S_ENTRY_B = 3'd1;
    localparam logic [2:0] S_MUL     = 3'd2;
    localparam logic [2:0] S_CONV    = 3'd3;
    localparam logic [2:0] S_RESULT  = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam logic [3:0] CMD_ADD    = 4'hA;
    localparam logic [3:0] CMD_SUB    = 4'hB;
    localparam logic [3:0] CMD_MUL    = 4'hC;
    localparam logic [3:0] CMD_CLEAR  = 4'hD;
    localparam logic [3:0] CMD_EQUALS = 4'hE;
    localparam logic [3:0] CMD_CE     = 4'hF;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [1:0] cmd_to_op(input logic [3:0] c);
        logic [1:0] op;
        case (c)
            CMD_ADD: op = OP_ADD;
            CMD_SUB: op = OP_SUB;
            CMD_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter: loads on start_i, shifts one bit per cycle
// for W cycles, then pulses done_o for one cycle with the BCD result on bcd_o.
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int W      = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [W-1:0]          bin_i,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_W    = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [W-1:0]        bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] adj_s;
    logic [CW-1:0]       cnt_q;
    logic                busy_q;

    // Add-3 correction on every BCD digit that would overflow after the shift
    always_comb begin
        adj_s = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Converter shift registers and cycle counter
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= CNT_ZERO;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= CNT_W;
            busy_q <= 1'b1;
        end else if (busy_q && (cnt_q != CNT_ZERO)) begin
            bcd_q  <= {adj_s[4*DIGITS-2:0], bin_q[W-1]};
            bin_q  <= {bin_q[W-2:0], 1'b0};
            cnt_q  <= cnt_q - CNT_ONE;
        end else begin
            busy_q <= 1'b0;
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_ZERO);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_param_core.sv
// Decimal calculator core: digit entry, ADD/SUB/MUL with an inline shift-add
// multiplier, sequential binary-to-BCD conversion and seven-segment display.
module calc_param_core
    import calc_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic [3:0]              cmd,
    output logic                    ready,
    output logic [DIGITS-1:0][6:0]  displays,
    output logic [1:0]              status,
    output logic [2:0]              EA,
    output logic [2:0]              PE
);

    localparam longint unsigned POW10  = pow10(DIGITS);
    localparam longint unsigned MAXV_L = POW10 - 64'd1;
    localparam int              W      = $clog2(POW10);
    localparam logic [W-1:0]    MAXV   = MAXV_L[W-1:0];
    localparam int              CW     = $clog2(W + 1);
    localparam int              EW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]   CNT_W   = CW'(W);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [EW-1:0]   ENT_MAX = EW'(DIGITS);
    localparam logic [EW-1:0]   ENT_ONE = EW'(1);

    logic [2:0]          state_q, state_d;
    logic [W-1:0]        a_q, ent_bin_q, res_q, mplier_q;
    logic [1:0]          op_q;
    logic [4*DIGITS-1:0] ent_bcd_q;
    logic [EW-1:0]       ent_cnt_q;
    logic [2*W-1:0]      mcand_q, prod_q, prod_step_s;
    logic [CW-1:0]       mcnt_q;

    logic                acc_s, is_digit_s, is_op_s, clear_s;
    logic [W:0]          sum_s;
    logic [W-1:0]        diff_s, ent_next_s, conv_bin_s;
    logic                add_err_s, sub_err_s, calc_err_s, mul_last_s, mul_err_s;
    logic                conv_start_s, conv_done_s, lead_s, err_disp_s;
    logic [4*DIGITS-1:0] conv_bcd_s, src_bcd_s;

    assign ready      = (state_q != S_MUL) && (state_q != S_CONV);
    assign acc_s      = cmd_valid && ready;
    assign is_digit_s = (cmd <= 4'd9);
    assign is_op_s    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
    assign clear_s    = acc_s && (cmd == CMD_CLEAR);

    // ent*10 + d; cannot overflow W bits because fewer than DIGITS digits are held
    assign ent_next_s  = (ent_bin_q << 3) + (ent_bin_q << 1) + {{(W-4){1'b0}}, cmd};
    assign sum_s       = {1'b0, a_q} + {1'b0, ent_bin_q};
    assign diff_s      = a_q - ent_bin_q;
    assign add_err_s   = sum_s > {1'b0, MAXV};
    assign sub_err_s   = ent_bin_q > a_q;
    assign prod_step_s = prod_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});
    assign mul_last_s  = (mcnt_q == CNT_ONE);
    assign mul_err_s   = prod_step_s > {{W{1'b0}}, MAXV};

    // Arithmetic error for the latched ADD/SUB operator
    always_comb begin
        case (op_q)
            OP_ADD:  calc_err_s = add_err_s;
            OP_SUB:  calc_err_s = sub_err_s;
            default: calc_err_s = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ENTRY_A: begin
                if (acc_s && is_op_s) begin
                    state_d = S_ENTRY_B;
                end else begin
                    state_d = S_ENTRY_A;
                end
            end
            S_ENTRY_B: begin
                if (clear_s) begin
                    state_d = S_ENTRY_A;
                end else if (acc_s && (cmd == CMD_EQUALS)) begin
                    if (op_q == OP_MUL) begin
                        state_d = S_MUL;
                    end else if (calc_err_s) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_CONV;
                    end
                end else begin
                    state_d = S_ENTRY_B;
                end
            end
            S_MUL: begin
                if (mul_last_s) begin
                    state_d = mul_err_s ? S_ERROR : S_CONV;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_CONV: begin
                if (conv_done_s) begin
                    state_d = S_RESULT;
                end else begin
                    state_d = S_CONV;
                end
            end
            S_RESULT: begin
                if (clear_s || (acc_s && is_digit_s)) begin
                    state_d = S_ENTRY_A;
                end else if (acc_s && is_op_s) begin
                    state_d = S_ENTRY_B;
                end else begin
                    state_d = S_RESULT;
                end
            end
            S_ERROR: begin
                if (clear_s) begin
                    state_d = S_ENTRY_A;
                end else begin
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_ERROR;
        endcase
    end

    // The converter starts on the same edge the state enters S_CONV
    assign conv_start_s = (state_d == S_CONV) && (state_q != S_CONV);
    assign conv_bin_s   = (state_q == S_MUL) ? prod_step_s[W-1:0]
                        : ((op_q == OP_ADD) ? sum_s[W-1:0] : diff_s);

    // State, operands, entry register and multiplier datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_ENTRY_A;
            a_q       <= '0;
            op_q      <= OP_ADD;
            ent_bcd_q <= '0;
            ent_bin_q <= '0;
            ent_cnt_q <= '0;
            res_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            mcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (clear_s) begin
                a_q       <= '0;
                op_q      <= OP_ADD;
                ent_bcd_q <= '0;
                ent_bin_q <= '0;
                ent_cnt_q <= '0;
                res_q     <= '0;
            end else begin
                case (state_q)
                    S_ENTRY_A, S_ENTRY_B: begin
                        if (!acc_s) begin
                            a_q <= a_q;
                        end else if (cmd == CMD_CE) begin
                            ent_bcd_q <= '0;
                            ent_bin_q <= '0;
                            ent_cnt_q <= '0;
                        end else if (is_digit_s) begin
                            if (ent_cnt_q < ENT_MAX) begin
                                ent_bcd_q <= {ent_bcd_q[4*DIGITS-5:0], cmd};
                                ent_bin_q <= ent_next_s;
                                ent_cnt_q <= ent_cnt_q + ENT_ONE;
                            end else begin
                                ent_cnt_q <= ent_cnt_q;
                            end
                        end else if (is_op_s) begin
                            op_q <= cmd_to_op(cmd);
                            if (state_q == S_ENTRY_A) begin
                                a_q       <= ent_bin_q;
                                ent_bcd_q <= '0;
                                ent_bin_q <= '0;
                                ent_cnt_q <= '0;
                            end else begin
                                a_q <= a_q;
                            end
                        end else if ((cmd == CMD_EQUALS) && (state_q == S_ENTRY_B)) begin
                            if (op_q == OP_MUL) begin
                                mcand_q  <= {{W{1'b0}}, a_q};
                                mplier_q <= ent_bin_q;
                                prod_q   <= '0;
                                mcnt_q   <= CNT_W;
                            end else begin
                                res_q <= conv_bin_s;
                            end
                        end else begin
                            a_q <= a_q;
                        end
                    end
                    S_MUL: begin
                        prod_q   <= prod_step_s;
                        mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[W-1:1]};
                        mcnt_q   <= mcnt_q - CNT_ONE;
                        if (mul_last_s) begin
                            res_q <= prod_step_s[W-1:0];
                        end else begin
                            res_q <= res_q;
                        end
                    end
                    S_RESULT: begin
                        if (acc_s && is_digit_s) begin
                            ent_bcd_q <= {{(4*DIGITS-4){1'b0}}, cmd};
                            ent_bin_q <= {{(W-4){1'b0}}, cmd};
                            ent_cnt_q <= ENT_ONE;
                        end else if (acc_s && is_op_s) begin
                            a_q       <= res_q;
                            op_q      <= cmd_to_op(cmd);
                            ent_bcd_q <= '0;
                            ent_bin_q <= '0;
                            ent_cnt_q <= '0;
                        end else begin
                            a_q <= a_q;
                        end
                    end
                    default: a_q <= a_q;
                endcase
            end
        end
    end

    calc_bin2bcd #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clock   (clock),
        .rst_n   (reset),
        .start_i (conv_start_s),
        .bin_i   (conv_bin_s),
        .done_o  (conv_done_s),
        .bcd_o   (conv_bcd_s)
    );

    assign err_disp_s = (state_q >= S_ERROR);

    // Display decode with leading-zero blanking; index 0 always shows a digit
    always_comb begin
        src_bcd_s = (state_q == S_RESULT) ? conv_bcd_s : ent_bcd_q;
        lead_s    = 1'b1;
        displays  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (err_disp_s) begin
                displays[i] = (i == 0) ? SEG_E : SEG_BLANK;
            end else if (lead_s && (i != 0) && (src_bcd_s[4*i +: 4] == 4'd0)) begin
                displays[i] = SEG_BLANK;
            end else begin
                displays[i] = bcd_to_seg(src_bcd_s[4*i +: 4]);
                lead_s      = 1'b0;
            end
        end
    end

    // Status is decoded from the current state only
    always_comb begin
        case (state_q)
            S_ENTRY_A, S_ENTRY_B: status = 2'b00;
            S_MUL, S_CONV:        status = 2'b01;
            S_RESULT:             status = 2'b10;
            default:              status = 2'b11;
        endcase
    end

    assign EA = state_q;
    assign PE = state_d;

endmodule

// File: tb/tb_calc_param_core.sv
// Scoreboard bench: a high-level calculator model predicts display, status and
// busy length per accepted command; a monitor compares when ready returns.
module tb_calc_param_core;

    localparam int  W8    = $clog2(10**8);
    localparam int  W4    = $clog2(10**4);
    localparam longint MAXV8 = 64'd99999999;

    typedef struct {
        bit        is_e;
        longint    val;
        logic [1:0] st;
        int        lat;
        bit        chk_lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic cmd_valid, cmd_valid4;
    logic [3:0] cmd, cmd4;
    logic ready, ready4;
    logic [7:0][6:0] displays;
    logic [3:0][6:0] displays4;
    logic [1:0] status, status4;
    logic [2:0] ea, pe, ea4, pe4;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    int     m_mode = 0;
    longint m_a = 0, m_ent = 0, m_res = 0;
    int     m_cnt = 0, m_op = 10;

    always #5 clock = ~clock;

    calc_param_core #(.DIGITS(8)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .ready(ready), .displays(displays), .status(status), .EA(ea), .PE(pe)
    );

    calc_param_core #(.DIGITS(4)) dut4 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid4), .cmd(cmd4),
        .ready(ready4), .displays(displays4), .status(status4), .EA(ea4), .PE(pe4)
    );

    function automatic logic [6:0] seg_of(input longint d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [8:0][6:0] exp_segs(input int nd, input bit is_e, input longint v);
        logic [8:0][6:0] s;
        longint x;
        x = v;
        for (int i = 0; i < 9; i++) s[i] = 7'h7F;
        if (is_e) begin
            s[0] = 7'h06;
        end else begin
            for (int i = 0; i < nd; i++) begin
                if (i == 0 || x != 0) s[i] = seg_of(x % 10);
                x = x / 10;
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic model(input logic [3:0] c, output exp_t e);
        longint r;
        e.lat = 0;
        e.chk_lat = 1'b1;
        if (c == 4'd13) begin
            m_mode = 0; m_a = 0; m_ent = 0; m_cnt = 0; m_op = 10;
        end else if (m_mode <= 1) begin
            if (c <= 4'd9) begin
                if (m_cnt < 8) begin m_ent = m_ent * 10 + longint'(c); m_cnt++; end
            end else if (c == 4'd15) begin
                m_ent = 0; m_cnt = 0;
            end else if (c >= 4'd10 && c <= 4'd12) begin
                if (m_mode == 0) begin m_a = m_ent; m_ent = 0; m_cnt = 0; m_mode = 1; end
                m_op = int'(c);
            end else if (c == 4'd14 && m_mode == 1) begin
                if (m_op == 10) r = m_a + m_ent;
                else if (m_op == 11) r = m_a - m_ent;
                else r = m_a * m_ent;
                if (r < 0 || r > MAXV8) begin
                    m_mode = 3;
                    e.lat = (m_op == 12) ? W8 : 0;
                end else begin
                    m_res = r;
                    m_mode = 2;
                    e.lat = (m_op == 12) ? 2 * W8 + 1 : W8 + 1;
                end
            end
        end else if (m_mode == 2) begin
            if (c <= 4'd9) begin
                m_ent = longint'(c); m_cnt = 1; m_mode = 0;
            end else if (c >= 4'd10 && c <= 4'd12) begin
                m_a = m_res; m_ent = 0; m_cnt = 0; m_op = int'(c); m_mode = 1;
            end
        end
        e.is_e = (m_mode == 3);
        e.val  = (m_mode == 2) ? m_res : m_ent;
        e.st   = (m_mode == 3) ? 2'b11 : ((m_mode == 2) ? 2'b10 : 2'b00);
    endtask

    task automatic strobe(input logic [3:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 400) begin @(posedge clock); #1; n++; end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: ready stayed %b after %0d cycles", ready, n);
        end
    endtask

    task automatic send_exp(input logic [3:0] c, input exp_t e);
        wait_ready();
        exp_q.push_back(e);
        strobe(c);
    endtask

    task automatic send(input logic [3:0] c);
        exp_t e;
        wait_ready();
        model(c, e);
        exp_q.push_back(e);
        strobe(c);
    endtask

    task automatic send4(input logic [3:0] c);
        int n;
        n = 0;
        while (!ready4 && n < 400) begin @(posedge clock); #1; n++; end
        cmd_valid4 = 1'b1;
        cmd4 = c;
        @(posedge clock); #1;
        cmd_valid4 = 1'b0;
    endtask

    // Monitor: an accepted command is seen at the negedge before its edge
    initial begin : monitor
        bit pend;
        int lowc;
        exp_t e;
        logic [8:0][6:0] es;
        pend = 1'b0;
        lowc = 0;
        forever begin
            @(negedge clock);
            if (pend) begin
                if (ready) begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL scoreboard_empty: response with no expectation");
                    end else begin
                        e  = exp_q.pop_front();
                        es = exp_segs(8, e.is_e, e.val);
                        chk("displays", 64'(displays), 64'(es[7:0]));
                        chk("status", 64'(status), 64'(e.st));
                        if (e.chk_lat) chk("busy_cycles", 64'(lowc), 64'(e.lat));
                    end
                end else if (lowc >= 400) begin
                    pend = 1'b0;
                    checks++; errors++;
                    $display("FAIL busy_timeout: ready low for %0d cycles", lowc);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    lowc++;
                end
            end
            if (!pend && cmd_valid && ready && reset) begin
                pend = 1'b1;
                lowc = 0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        exp_t ab;
        logic [8:0][6:0] es;
        int n, r;
        reset = 1'b0; cmd_valid = 1'b0; cmd = 4'd0; cmd_valid4 = 1'b0; cmd4 = 4'd0;
        #12;
        es = exp_segs(8, 1'b0, 0);
        chk("reset_ea", 64'(ea), 64'd0);
        chk("reset_pe", 64'(pe), 64'd0);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_status", 64'(status), 64'd0);
        chk("reset_displays", 64'(displays), 64'(es[7:0]));
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Scenario 1: 12 + 3
        send(4'd1); send(4'd2); send(4'hA); send(4'd3); send(4'hE);
        // Scenario 2: 7 * 6 with a CLEAR dropped while busy, then chain + 8
        send(4'hD); send(4'd7); send(4'hC); send(4'd6); send(4'hE);
        repeat (5) @(posedge clock);
        #1;
        chk("busy_ea", 64'(ea), 64'd2);
        chk("busy_pe", 64'(pe), 64'd2);
        strobe(4'hD);
        send(4'hA); send(4'd8); send(4'hE);
        send(4'hE);
        // Scenario 3: 5 - 9 errors; digit ignored; CLEAR recovers
        send(4'd5); send(4'hB); send(4'd9); send(4'hE); send(4'd3); send(4'hD);
        // Scenario 4: digit limit then overflow
        for (int i = 0; i < 9; i++) send(4'd9);
        send(4'hA); send(4'd1); send(4'hE); send(4'hD);
        // CE keeps state; operator replacement in ENTRY_B
        send(4'd4); send(4'd0); send(4'hA); send(4'd7); send(4'hF); send(4'd2);
        send(4'hB); send(4'hE);

        // Scenario 5: reset mid-multiply
        send(4'hD); send(4'd9); send(4'hC); send(4'd9);
        ab.is_e = 1'b0; ab.val = 0; ab.st = 2'b00; ab.lat = 0; ab.chk_lat = 1'b0;
        send_exp(4'hE, ab);
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_ea", 64'(ea), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        m_mode = 0; m_a = 0; m_ent = 0; m_cnt = 0; m_op = 10;
        @(posedge clock); #1;
        es = exp_segs(8, 1'b0, 0);
        chk("abort_displays", 64'(displays), 64'(es[7:0]));
        chk("abort_status", 64'(status), 64'd0);

        // Randomized command stream
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 99));
            if (m_mode == 3 && r < 40) send(4'hD);
            else if (r < 55) send(4'($urandom_range(0, 9)));
            else if (r < 65) send(4'hA);
            else if (r < 72) send(4'hB);
            else if (r < 78) send(4'hC);
            else if (r < 90) send(4'hE);
            else if (r < 94) send(4'hF);
            else send(4'hD);
        end
        wait_ready();
        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Scenario 6: DIGITS=4 instance
        send4(4'hD);
        for (int i = 0; i < 4; i++) send4(4'd9);
        send4(4'hA); send4(4'd1); send4(4'hE);
        es = exp_segs(4, 1'b1, 0);
        chk("d4_err_status", 64'(status4), 64'd3);
        chk("d4_err_displays", 64'(displays4), 64'(es[3:0]));
        send4(4'hD);
        send4(4'd9); send4(4'd9); send4(4'hC); send4(4'd9); send4(4'd9); send4(4'hE);
        n = 0;
        while (!ready4 && n < 200) begin n++; @(posedge clock); #1; end
        es = exp_segs(4, 1'b0, 9801);
        chk("d4_mul_busy", 64'(n), 64'(2 * W4 + 1));
        chk("d4_mul_displays", 64'(displays4), 64'(es[3:0]));
        chk("d4_mul_status", 64'(status4), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
